// File: rtl/sync_fifo_push_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between N_REQ valid/ready requesters.
// Define FIFO_PUSH_ARB_BURST_LOCK_EN to keep multi-beat packets contiguous (bounded by MAX_BURST).
module sync_fifo_push_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned W_BURST   = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]       req_last_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   flush_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   locked_o,
    output logic [WIDTH-1:0]       fifo_wdata_o,
    output logic                   fifo_wen_o,
    input  logic                   fifo_full_i
);

    localparam logic [N_REQ-1:0] PtrRst = N_REQ'(1);

    function automatic logic [N_REQ-1:0] rotl(input logic [N_REQ-1:0] x);
        return (x << 1) | (x >> (N_REQ - 1));
    endfunction

    function automatic logic [N_REQ-1:0] lowest(input logic [N_REQ-1:0] x);
        return x & (~x + N_REQ'(1));
    endfunction

    logic [N_REQ-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] upper, grant_idle, grant;

    // Requests at or above ptr win; otherwise wrap around to the lowest request.
    assign upper      = req_i & ~(ptr_q - N_REQ'(1));
    assign grant_idle = (|upper) ? lowest(upper) : lowest(req_i);

    assign grant_o     = grant;
    assign req_ready_o = grant & {N_REQ{!fifo_full_i && !flush_i}};
    assign fifo_wen_o  = |(req_i & req_ready_o);

    always_comb begin
        fifo_wdata_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) fifo_wdata_o |= req_data_i[i*WIDTH +: WIDTH];
        end
    end

`ifdef FIFO_PUSH_ARB_BURST_LOCK_EN
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e             st_q, st_d;
    logic [N_REQ-1:0]   owner_q, owner_d;
    logic [W_BURST-1:0] cnt_q, cnt_d;

    // Outputs are forced quiet while reset is asserted, independent of req_i.
    assign grant    = !rst_n ? '0 : (st_q == StLocked) ? owner_q : grant_idle;
    assign locked_o = (st_q == StLocked);

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            st_d    = StIdle;
            owner_d = '0;
            cnt_d   = '0;
            ptr_d   = PtrRst;
        end else if (fifo_wen_o) begin
            if (st_q == StIdle) begin
                if ((|(req_last_i & grant)) || (MAX_BURST == 1)) begin
                    ptr_d = rotl(grant);
                end else begin
                    st_d    = StLocked;
                    owner_d = grant;
                    cnt_d   = W_BURST'(1);
                end
            end else if ((|(req_last_i & owner_q)) || (cnt_q == W_BURST'(MAX_BURST - 1))) begin
                st_d  = StIdle;
                cnt_d = '0;
                ptr_d = rotl(owner_q);
            end else begin
                cnt_d = cnt_q + W_BURST'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= PtrRst;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef FORMAL
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q < W_BURST'(MAX_BURST));
`endif
`else
    logic unused_last;
    logic unused_cfg;
    assign unused_last = ^req_last_i;
    assign unused_cfg  = ^W_BURST'(MAX_BURST);

    assign grant    = !rst_n ? '0 : grant_idle;
    assign locked_o = 1'b0;

    always_comb begin
        ptr_d = ptr_q;
        if (flush_i)         ptr_d = PtrRst;
        else if (fifo_wen_o) ptr_d = rotl(grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= PtrRst;
        else        ptr_q <= ptr_d;
    end
`endif

`ifdef FORMAL
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_o));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full_i |-> !fifo_wen_o);
    for (genvar i = 0; i < N_REQ; i++) begin : g_hold
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req_i[i] && !req_ready_o[i]) |=>
            (req_i[i] && $stable(req_data_i[i*WIDTH +: WIDTH])));
    end
`endif

endmodule
